// File: rtl/spaceship_fire_ctrl_if.sv
// Bundle for the fire controller: inputs from the ship-position stage and
// outputs toward the LED board / score display.
interface spaceship_fire_ctrl_if #(
  parameter int ROW_W   = 3,
  parameter int SCORE_W = 8
);
  logic [3:0]         ship_pos;
  logic               fire;
  logic               tick;
  logic               bullet_active;
  logic [3:0]         bullet_col;
  logic [ROW_W-1:0]   bullet_row;
  logic [3:0]         target_col;
  logic [SCORE_W-1:0] score;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [15:0]        led;

  // Game-side view: drives the inputs and observes the results.
  modport master (
    output ship_pos, fire, tick,
    input  bullet_active, bullet_col, bullet_row, target_col, score,
           hit_pulse, miss_pulse, led
  );

  // Controller view.
  modport slave (
    input  ship_pos, fire, tick,
    output bullet_active, bullet_col, bullet_row, target_col, score,
           hit_pulse, miss_pulse, led
  );
endinterface

// File: rtl/spaceship_fire_ctrl.sv
// Spaceship fire controller: captures a fire button edge, flies one bullet
// for ROWS game ticks, resolves hit/miss against an LFSR-placed target,
// keeps a saturating score and drives a registered 16-LED composite.
//
// Optional feature: define SPACESHIP_FIRE_COOLDOWN_EN to add a COOL state
// that locks out fire for COOLDOWN ticks after each resolution.
//
// state  | meaning
// IDLE   | waiting for a fire edge
// FLIGHT | bullet in flight, row advances on tick
// RESULT | one cycle, hit/miss pulse visible
// COOL   | fire lockout, counts COOLDOWN ticks (macro build only)
module spaceship_fire_ctrl #(
  parameter int         ROWS      = 8,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         COOLDOWN  = 4
) (
  input logic                  Clk,
  input logic                  rst,
  spaceship_fire_ctrl_if.slave bus
);

  localparam int             ROW_W    = $clog2(ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  if (ROWS < 2 || LFSR_SEED == 8'h00 || COOLDOWN < 1) begin : g_bad_param
    $error("spaceship_fire_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    RESULT = 2'd2
`ifdef SPACESHIP_FIRE_COOLDOWN_EN
    , COOL = 2'd3
`endif
  } state_t;

  // Target column from LFSR low bits; column 0 is never reachable by the
  // ship, so it folds onto column 2.
  function automatic logic [3:0] col_map(input logic [7:0] v);
    logic [3:0] c;
    c = {v[2:0], 1'b0};
    return (c == 4'd0) ? 4'd2 : c;
  endfunction

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q;
  logic               s1_q, s2_q, s3_q;
  logic               fire_rise;
  logic               launch, resolve, row_inc;
  logic               active_q;
  logic [3:0]         col_q;
  logic [ROW_W-1:0]   row_q;
  logic [3:0]         target_q;
  logic [SCORE_W-1:0] score_q;
  logic               hit_q, miss_q;
  logic [15:0]        led_q, led_d;

`ifdef SPACESHIP_FIRE_COOLDOWN_EN
  localparam int CNT_W = $clog2(COOLDOWN + 1);
  logic [CNT_W-1:0] cool_cnt_q;
`endif

  assign fire_rise = s2_q & ~s3_q;

  // State register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    resolve = 1'b0;
    row_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (fire_rise) begin
          launch  = 1'b1;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (bus.tick) begin
          if (row_q == ROW_LAST) begin
            resolve = 1'b1;
            state_d = RESULT;
          end else begin
            row_inc = 1'b1;
          end
        end
      end
      RESULT: begin
`ifdef SPACESHIP_FIRE_COOLDOWN_EN
        state_d = COOL;
`else
        state_d = IDLE;
`endif
      end
`ifdef SPACESHIP_FIRE_COOLDOWN_EN
      COOL: begin
        if (bus.tick && cool_cnt_q == CNT_W'(1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // LED composite from current inputs/state, registered next edge.
  always_comb begin
    led_d = (16'd1 << bus.ship_pos) | (16'd1 << target_q);
    if (active_q) led_d = led_d | (16'd1 << col_q);
  end

  // Datapath: sync chain, LFSR, bullet, score, target, pulses, LEDs.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      lfsr_q   <= LFSR_SEED;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      active_q <= 1'b0;
      col_q    <= 4'd0;
      row_q    <= '0;
      target_q <= col_map(LFSR_SEED);
      score_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      led_q    <= 16'd0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      s1_q   <= bus.fire;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      led_q  <= led_d;
      if (launch) begin
        col_q    <= bus.ship_pos;
        row_q    <= '0;
        active_q <= 1'b1;
      end else if (row_inc) begin
        row_q <= row_q + ROW_W'(1);
      end
      if (resolve) begin
        active_q <= 1'b0;
        row_q    <= '0;
        if (col_q == target_q) begin
          hit_q    <= 1'b1;
          target_q <= col_map(lfsr_q);
          if (score_q != '1) score_q <= score_q + SCORE_W'(1);
        end else begin
          miss_q <= 1'b1;
        end
      end
    end
  end

`ifdef SPACESHIP_FIRE_COOLDOWN_EN
  // Lockout down-counter, loaded at resolution, decremented per tick in COOL.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cool_cnt_q <= '0;
    end else if (resolve) begin
      cool_cnt_q <= CNT_W'(COOLDOWN);
    end else if (state_q == COOL && bus.tick && cool_cnt_q != '0) begin
      cool_cnt_q <= cool_cnt_q - CNT_W'(1);
    end
  end
`endif

  assign bus.bullet_active = active_q;
  assign bus.bullet_col    = col_q;
  assign bus.bullet_row    = row_q;
  assign bus.target_col    = target_q;
  assign bus.score         = score_q;
  assign bus.hit_pulse     = hit_q;
  assign bus.miss_pulse    = miss_q;
  assign bus.led           = led_q;

endmodule

// File: tb/tb_spaceship_fire_ctrl.sv
// Self-checking bench for spaceship_fire_ctrl (small score width to reach
// saturation quickly). Resolution expectations go through a scoreboard queue.
module tb_spaceship_fire_ctrl;
  localparam int ROWS    = 8;
  localparam int ROW_W   = 3;
  localparam int SCORE_W = 2;

  logic Clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  spaceship_fire_ctrl_if #(.ROW_W(ROW_W), .SCORE_W(SCORE_W)) bus();

  spaceship_fire_ctrl #(
    .ROWS(ROWS), .SCORE_W(SCORE_W), .LFSR_SEED(8'hA5), .COOLDOWN(4)
  ) dut (
    .Clk(Clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic [3:0]         target;
  } exp_t;

  exp_t               sb[$];
  logic [7:0]         m_lfsr;
  logic [SCORE_W-1:0] exp_score;
  logic [3:0]         exp_target;
  logic [3:0]         launch_col;

  // Reference 8-bit Fibonacci LFSR, taps 8,6,5,4.
  always @(posedge Clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] map_col(input logic [7:0] v);
    logic [3:0] c;
    c = {v[2:0], 1'b0};
    if (c == 4'd0) c = 4'd2;
    return c;
  endfunction

  function automatic logic [15:0] led_of(input logic [3:0] s, input logic [3:0] t,
                                         input logic a, input logic [3:0] c);
    logic [15:0] v;
    v = (16'd1 << s) | (16'd1 << t);
    if (a) v = v | (16'd1 << c);
    return v;
  endfunction

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(negedge Clk);
      bus.tick = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic apply_reset();
    bus.fire = 1'b0;
    bus.tick = 1'b0;
    @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    exp_score  = '0;
    exp_target = 4'd10;
    sb.delete();
  endtask

  // Press fire at column col; launch expected exactly 3 edges later.
  task automatic fire_shot(input logic [3:0] col, input bit tick_at_launch);
    bus.ship_pos = col;
    bus.fire     = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (bus.bullet_active !== 1'b0) begin
      failures++;
      $display("FAIL launch_early active=%0b required=0", bus.bullet_active);
    end
    if (tick_at_launch) bus.tick = 1'b1;
    @(negedge Clk);
    bus.tick = 1'b0;
    bus.fire = 1'b0;
    checks++;
    if (bus.bullet_active !== 1'b1 || bus.bullet_row !== '0 || bus.bullet_col !== col) begin
      failures++;
      $display("FAIL launch active=%0b row=%0d col=%0d required active=1 row=0 col=%0d",
               bus.bullet_active, bus.bullet_row, bus.bullet_col, col);
    end
    launch_col = col;
  endtask

  // Final tick: push expectation, then compare the RESULT cycle against it.
  task automatic resolve_shot(input bit drain);
    exp_t e;
    checks++;
    if (bus.bullet_row !== ROW_W'(ROWS - 1) || bus.bullet_active !== 1'b1) begin
      failures++;
      $display("FAIL pre_resolve row=%0d active=%0b required row=%0d active=1",
               bus.bullet_row, bus.bullet_active, ROWS - 1);
    end
    e.hit = (launch_col == exp_target);
    if (e.hit) begin
      if (exp_score != '1) exp_score = exp_score + 1'b1;
      exp_target = map_col(m_lfsr);
    end
    e.score  = exp_score;
    e.target = exp_target;
    sb.push_back(e);
    bus.tick = 1'b1;
    @(negedge Clk);
    bus.tick = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty size=0 required=1");
    end else begin
      e = sb.pop_front();
      if (bus.hit_pulse !== e.hit || bus.miss_pulse !== !e.hit) begin
        failures++;
        $display("FAIL result_pulse hit=%0b miss=%0b required hit=%0b miss=%0b",
                 bus.hit_pulse, bus.miss_pulse, e.hit, !e.hit);
      end
      checks++;
      if (bus.score !== e.score || bus.target_col !== e.target ||
          bus.bullet_active !== 1'b0 || bus.bullet_row !== '0) begin
        failures++;
        $display("FAIL result_state score=%0d target=%0d active=%0b row=%0d required score=%0d target=%0d active=0 row=0",
                 bus.score, bus.target_col, bus.bullet_active, bus.bullet_row, e.score, e.target);
      end
    end
    @(negedge Clk);
    checks++;
    if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width hit=%0b miss=%0b required 0 0", bus.hit_pulse, bus.miss_pulse);
    end
`ifdef SPACESHIP_FIRE_COOLDOWN_EN
    if (drain) tick_n(4);
`else
    if (drain) @(negedge Clk);
`endif
  endtask

  task automatic test_reset();
    bus.ship_pos = 4'd10;
    bus.fire     = 1'b0;
    bus.tick     = 1'b0;
    rst          = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.bullet_active !== 1'b0 || bus.bullet_row !== '0 || bus.bullet_col !== 4'd0 ||
        bus.score !== '0 || bus.target_col !== 4'd10 || bus.hit_pulse !== 1'b0 ||
        bus.miss_pulse !== 1'b0 || bus.led !== 16'd0) begin
      failures++;
      $display("FAIL reset_state active=%0b row=%0d col=%0d score=%0d target=%0d led=%h required 0 0 0 0 10 0000",
               bus.bullet_active, bus.bullet_row, bus.bullet_col, bus.score, bus.target_col, bus.led);
    end
    rst = 1'b1;
    exp_score  = '0;
    exp_target = 4'd10;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.led !== led_of(4'd10, 4'd10, 1'b0, 4'd0)) begin
      failures++;
      $display("FAIL idle_led led=%h required=%h", bus.led, led_of(4'd10, 4'd10, 1'b0, 4'd0));
    end
    tick_n(3);
    checks++;
    if (bus.bullet_active !== 1'b0 || bus.bullet_row !== '0) begin
      failures++;
      $display("FAIL idle_tick active=%0b row=%0d required 0 0", bus.bullet_active, bus.bullet_row);
    end
  endtask

  task automatic test_miss();
    fire_shot(4'd4, 1'b0);
    tick_n(ROWS - 1);
    resolve_shot(1'b1);
  endtask

  task automatic test_hit();
    fire_shot(4'd10, 1'b1);
    tick_n(3);
    checks++;
    if (bus.bullet_row !== ROW_W'(3)) begin
      failures++;
      $display("FAIL row_count row=%0d required=3", bus.bullet_row);
    end
    checks++;
    if (bus.led !== led_of(4'd10, exp_target, 1'b1, 4'd10)) begin
      failures++;
      $display("FAIL flight_led led=%h required=%h", bus.led, led_of(4'd10, exp_target, 1'b1, 4'd10));
    end
    tick_n(ROWS - 4);
    resolve_shot(1'b1);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      fire_shot(exp_target, k[0]);
      tick_n(ROWS - 1);
      resolve_shot(1'b1);
    end
    checks++;
    if (bus.score !== 2'd3) begin
      failures++;
      $display("FAIL saturate score=%0d required=3", bus.score);
    end
  endtask

  task automatic test_refire();
    fire_shot(4'd4, 1'b0);
    tick_n(2);
    bus.ship_pos = 4'd12;
    for (int k = 0; k < 2; k++) begin
      bus.fire = 1'b1;
      repeat (4) @(negedge Clk);
      bus.fire = 1'b0;
      repeat (4) @(negedge Clk);
    end
    checks++;
    if (bus.bullet_active !== 1'b1 || bus.bullet_col !== 4'd4 || bus.bullet_row !== ROW_W'(2)) begin
      failures++;
      $display("FAIL refire active=%0b col=%0d row=%0d required active=1 col=4 row=2",
               bus.bullet_active, bus.bullet_col, bus.bullet_row);
    end
    checks++;
    if (bus.led !== led_of(4'd12, exp_target, 1'b1, 4'd4)) begin
      failures++;
      $display("FAIL refire_led led=%h required=%h", bus.led, led_of(4'd12, exp_target, 1'b1, 4'd4));
    end
    tick_n(ROWS - 3);
    resolve_shot(1'b1);
    repeat (6) @(negedge Clk);
    checks++;
    if (bus.bullet_active !== 1'b0) begin
      failures++;
      $display("FAIL refire_queued active=%0b required=0", bus.bullet_active);
    end
  endtask

  task automatic test_reset_midflight();
    bit pulse_seen;
    fire_shot(4'd6, 1'b0);
    tick_n(5);
    checks++;
    if (bus.bullet_row !== ROW_W'(5) || bus.score === '0) begin
      failures++;
      $display("FAIL pre_abort row=%0d score=%0d required row=5 score nonzero", bus.bullet_row, bus.score);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.bullet_active !== 1'b0 || bus.score !== '0 || bus.target_col !== 4'd10 ||
        bus.bullet_row !== '0 || bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0 || bus.led !== 16'd0) begin
      failures++;
      $display("FAIL abort_state active=%0b score=%0d target=%0d row=%0d led=%h required 0 0 10 0 0000",
               bus.bullet_active, bus.score, bus.target_col, bus.bullet_row, bus.led);
    end
    @(negedge Clk);
    rst = 1'b1;
    exp_score  = '0;
    exp_target = 4'd10;
    sb.delete();
    pulse_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) bus.tick = 1'b1;
      @(negedge Clk);
      bus.tick = 1'b0;
      if (bus.hit_pulse || bus.miss_pulse || bus.bullet_active) pulse_seen = 1'b1;
    end
    checks++;
    if (pulse_seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse seen=%0b required=0", pulse_seen);
    end
  endtask

`ifdef SPACESHIP_FIRE_COOLDOWN_EN
  task automatic test_cooldown();
    fire_shot(4'd2, 1'b0);
    tick_n(ROWS - 1);
    resolve_shot(1'b0);
    tick_n(2);
    bus.fire = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (bus.bullet_active !== 1'b0) begin
      failures++;
      $display("FAIL cool_lockout active=%0b required=0", bus.bullet_active);
    end
    bus.fire = 1'b0;
    repeat (4) @(negedge Clk);
    tick_n(1);
    checks++;
    if (bus.bullet_active !== 1'b0) begin
      failures++;
      $display("FAIL cool_early active=%0b required=0", bus.bullet_active);
    end
    tick_n(1);
    fire_shot(4'd6, 1'b0);
    tick_n(ROWS - 1);
    resolve_shot(1'b1);
  endtask
`else
  task automatic test_back_to_back();
    fire_shot(4'd2, 1'b0);
    tick_n(ROWS - 1);
    resolve_shot(1'b0);
    fire_shot(4'd6, 1'b0);
    tick_n(ROWS - 1);
    resolve_shot(1'b1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.ship_pos = 4'd0;
    bus.fire     = 1'b0;
    bus.tick     = 1'b0;
    test_reset();
    test_miss();
    test_hit();
    test_refire();
    test_saturate();
    test_reset_midflight();
`ifdef SPACESHIP_FIRE_COOLDOWN_EN
    test_cooldown();
`else
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
